// File: rtl/ysyx_23060332_dmem.sv
// Data-memory responder: accepts one valid/ready request at a time and performs
// a byte-masked access after LATENCY busy cycles. Load and store data are right-justified.
module ysyx_23060332_dmem #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic        accept, do_access, do_write;
  logic        a_wen;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_wmask;
  logic [1:0]  off;
  logic [31:0] rel, wshift, rword;
  logic [AW-1:0] idx;
  logic [7:0]  lane_m;
  logic        range_err, misalign;
  logic        unused_wmask_hi;

  assign unused_wmask_hi = ^req_wmask[7:4];

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid && req_ready;

  // With zero latency the access happens on the accept edge, so it uses the live inputs.
  assign a_wen   = (state_q == IDLE) ? req_wen         : wen_q;
  assign a_addr  = (state_q == IDLE) ? req_addr        : addr_q;
  assign a_wdata = (state_q == IDLE) ? req_wdata       : wdata_q;
  assign a_wmask = (state_q == IDLE) ? req_wmask[3:0]  : wmask_q;

  assign do_access = ((state_q == IDLE) && accept && (LATENCY == 0)) ||
                     ((state_q == BUSY) && (cnt_q == 4'd0));

  assign off       = a_addr[1:0];
  assign rel       = a_addr - BASE;
  assign idx       = rel[AW+1:2];
  assign range_err = (a_addr < BASE) || ((rel >> 2) >= 32'(DEPTH));
  assign lane_m    = {4'b0000, a_wmask} << off;
  assign misalign  = (lane_m[7:4] != 4'b0000);
  assign wshift    = a_wdata << {off, 3'b000};
  assign rword     = mem[idx] >> {off, 3'b000};
  assign do_write  = do_access && a_wen && !range_err && !misalign && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_m[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask[3:0];
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) cnt_d = 4'(cnt_q - 4'd1);
        else               state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (do_access) begin
      rdata_d = (a_wen || range_err) ? 32'd0 : rword;
      err_d   = range_err || (a_wen && misalign);
    end
  end
endmodule

// File: doc/ysyx_23060332_dmem.md
Name: ysyx_23060332_dmem

Overview:
Data-memory responder for the core's load/store path. It accepts one read or write request at a time over a valid/ready request channel. It performs a byte-masked access on an internal word array after a programmable delay, then returns data and status over a valid/ready response channel. Byte alignment is handled here: load data is returned right-justified, so the load/store logic only sign- or zero-extends the low bits. Store data is supplied right-justified and shifted into the correct byte lanes here.

Parameters:
DEPTH, 1024, number of 32-bit words in the array.
BASE, 32'h8000_0000, byte address of word 0.
LATENCY, 1, number of BUSY cycles between request accept and response; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_wen  input  1  1 = write, 0 = read.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-justified.
req_wmask  input  8  byte enables, right-justified; bits [7:4] ignored; 8'h0F word, 8'h03 half, 8'h01 byte.
resp_valid  output  1  response present.
resp_ready  input  1  consumer takes response.
resp_rdata  output  32  load data, right-justified; 0 for writes and errors.
resp_err  output  1  address out of range or store crosses a word boundary.

Behaviour:
- Reset, sampled on a rising edge while rst=1:
  - state <= IDLE.
  - resp_valid <= 0, resp_rdata <= 0, resp_err <= 0.
  - req_ready reads 0 while rst=1.
  - Array contents are not reset.
- Reset mid-operation: any pending request is dropped. A write is lost unless it already committed on an earlier edge.
- States: IDLE, BUSY, RESP.
  - req_ready = (state==IDLE) && !rst.
  - resp_valid = (state==RESP).
- IDLE:
  - On req_valid && req_ready, latch wen, addr, wdata and wmask[3:0].
  - If LATENCY>0: cnt <= LATENCY-1, next state BUSY.
  - If LATENCY==0: perform the access on this same edge, next state RESP.
- BUSY:
  - If cnt!=0: cnt <= cnt-1.
  - If cnt==0: perform the access on this edge, next state RESP.
- Timing: with the handshake in cycle 0, resp_valid is first high in cycle LATENCY+1.
- RESP:
  - resp_rdata and resp_err stay stable until resp_ready=1.
  - On resp_valid && resp_ready, next state IDLE.
  - A new request cannot be accepted in the same cycle; the minimum request spacing is LATENCY+2 cycles.
- Access decode:
  - off = addr[1:0].
  - idx = (addr-BASE)>>2.
  - range_err = (addr < BASE) || (idx >= DEPTH).
- Write (wen=1):
  - lane mask m = {4'b0, wmask[3:0]} << off (8 bits).
  - Misaligned if m[7:4]!=0.
  - If range_err or misaligned: no array change, resp_err=1.
  - Otherwise, for each i in 0..3 with m[i]=1: byte i of mem[idx] <= byte i of (wdata << 8*off).
  - wmask[3:0]==0 with wen=1: no array change, resp_err=0.
  - resp_rdata = 0 for all writes.
- Read (wen=0):
  - If range_err: resp_rdata=0, resp_err=1.
  - Otherwise resp_rdata = mem[idx] >> 8*off, zero-filled from the top; resp_err=0.
  - Reads never flag misalignment; req_wmask is ignored.
- Inputs are sampled only at the accept edge. Changes to req_* in BUSY or RESP have no effect.
- A read issued after a write completes returns the written data.
- One outstanding request maximum; no reordering.

Test Plan:
1. Word store then load, LATENCY=1: write addr 8000_0010, data DEADBEEF, mask 0F; then read 8000_0010 -> write resp_valid in cycle 2 with err=0; read rdata=DEADBEEF, err=0.
2. Byte lanes: write 8000_0020 = 11223344 (mask 0F), then write byte 0xAB at 8000_0022 (wdata=000000AB, mask 01); read 8000_0020 -> 11AB3344; read 8000_0023 -> 00000011.
3. Halfword: write 8000_0030 = 0, then write half BEEF (mask 03) at 8000_0032; read 8000_0030 -> BEEF0000. Half write at 8000_0033 -> resp_err=1, word unchanged at BEEF0000.
4. Range: read 7FFF_FFFC and read BASE+4*DEPTH -> resp_err=1, rdata=0. Write to BASE+4*DEPTH -> err=1 and no aliasing into word 0.
5. Backpressure and latency, LATENCY=3: hold resp_ready=0 for 5 cycles -> resp_valid first high in cycle 4, rdata stable throughout, req_ready=0 until one cycle after the resp_ready handshake. Repeat with LATENCY=0 -> resp_valid in cycle 1.
6. Reset mid-operation: accept a write of 12345678 to 8000_0040 (LATENCY=3), assert rst in cycle 2 -> resp_valid=0, state IDLE, later read returns the old value. Reset asserted while in RESP -> resp_valid=0 on the next cycle.
